pulse_debouncer: RTL and testbench

Parametrised multi-channel debouncer and edge detector for push-button and switch inputs on the processor board. Each channel synchronises a raw asynchronous input, qualifies it over a programmable number of consecutive sample ticks, and produces a clean level plus single-clock rise, fall and auto-repeat pulses. It sits between the board I/O pins and the control FSM / register-file write logic, and is clocked by the system clock. Sampling is paced by an external clock-enable strobe, typically from the 500 Hz divider.

---
 rtl/pulse_debouncer_if.sv | 30 +++
 rtl/pulse_debouncer.sv | 133 +++++++++++++
 tb/tb_pulse_debouncer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_debouncer_if.sv
// Bundle of the debouncer's sampled inputs and its qualified outputs.
// The auto-repeat output is called rpt because "repeat" is a reserved word.
interface pulse_debouncer_if #(
    parameter int CHANNELS = 4
);
    logic                tick;
    logic [CHANNELS-1:0] sample;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] rpt;

    modport master (
        output tick,
        output sample,
        input  level,
        input  rise,
        input  fall,
        input  rpt
    );

    modport slave (
        input  tick,
        input  sample,
        output level,
        output rise,
        output fall,
        output rpt
    );
endinterface

// File: rtl/pulse_debouncer.sv
// Multi-channel debouncer and edge detector. Each channel synchronises its raw
// input, accepts a new level only after STABLE_CNT consecutive agreeing ticks,
// and emits one-clock rise, fall and auto-repeat pulses.
module pulse_debouncer #(
    parameter int CHANNELS     = 4,
    parameter int STABLE_CNT   = 9,
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 50
) (
    input  logic              clk,
    input  logic              rst,
    pulse_debouncer_if.slave  bus
);
    localparam int CW   = $clog2(STABLE_CNT + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);
    // A zero initial delay turns the repeat machinery off entirely.
    localparam bit            RPT_EN    = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0]                  s_sync;
    logic [CHANNELS-1:0]                  level_q, level_d;
    logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0][RW-1:0]          rcnt_q, rcnt_d;
    state_t [CHANNELS-1:0]                state_q, state_d;
    logic [CHANNELS-1:0]                  rise_q, rise_d;
    logic [CHANNELS-1:0]                  fall_q, fall_d;
    logic [CHANNELS-1:0]                  rpt_q, rpt_d;

    assign s_sync    = sync_q[SYNC_STAGES-1];
    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.rpt   = rpt_q;

    // Next-state: synchroniser shift, stability qualification and repeat FSM per channel.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], bus.sample};
        level_d = level_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
        rpt_d   = '0;

        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (bus.tick) begin
                // Any agreement with the current level restarts qualification.
                if (s_sync[ch] == level_q[ch]) begin
                    cnt_d[ch] = '0;
                end else if (cnt_q[ch] == CNT_LAST) begin
                    level_d[ch] = s_sync[ch];
                    cnt_d[ch]   = '0;
                    rise_d[ch]  = s_sync[ch];
                    fall_d[ch]  = ~s_sync[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end

                if (RPT_EN) begin
                    // An accepted fall wins over any repeat due on the same tick.
                    if (fall_d[ch]) begin
                        state_d[ch] = IDLE;
                        rcnt_d[ch]  = '0;
                    end else if (rise_d[ch]) begin
                        state_d[ch] = DELAY;
                        rcnt_d[ch]  = '0;
                    end else begin
                        case (state_q[ch])
                            DELAY: begin
                                if (rcnt_q[ch] == DLY_LAST) begin
                                    rpt_d[ch]   = 1'b1;
                                    rcnt_d[ch]  = '0;
                                    state_d[ch] = REPEAT;
                                end else begin
                                    rcnt_d[ch] = rcnt_q[ch] + 1'b1;
                                end
                            end
                            REPEAT: begin
                                if (rcnt_q[ch] == RATE_LAST) begin
                                    rpt_d[ch]  = 1'b1;
                                    rcnt_d[ch] = '0;
                                end else begin
                                    rcnt_d[ch] = rcnt_q[ch] + 1'b1;
                                end
                            end
                            default: begin
                                state_d[ch] = IDLE;
                            end
                        endcase
                    end
                end
            end
        end
    end

    // State registers; asynchronous reset clears every channel and suppresses pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            rpt_q   <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
            end
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            rpt_q   <= rpt_d;
        end
    end
endmodule

// File: tb/tb_pulse_debouncer.sv
// Directed bench for pulse_debouncer: default build, a short-repeat build and
// a single-tick build with repeat disabled, all sharing clock and reset.
module tb_pulse_debouncer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pulse_debouncer_if #(.CHANNELS(4)) if_a ();
    pulse_debouncer_if #(.CHANNELS(4)) if_b ();
    pulse_debouncer_if #(.CHANNELS(4)) if_c ();

    pulse_debouncer #(
        .CHANNELS(4), .STABLE_CNT(9), .SYNC_STAGES(2), .REPEAT_DELAY(250), .REPEAT_RATE(50)
    ) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

    pulse_debouncer #(
        .CHANNELS(4), .STABLE_CNT(9), .SYNC_STAGES(2), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    pulse_debouncer #(
        .CHANNELS(4), .STABLE_CNT(1), .SYNC_STAGES(2), .REPEAT_DELAY(0), .REPEAT_RATE(1)
    ) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present tick for the coming edge, then observe just after that edge.
    task automatic step(input logic t);
        if_a.tick = t;
        if_b.tick = t;
        if_c.tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_a.sample = '0;
        if_b.sample = '0;
        if_c.sample = '0;
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        if_a.sample = 4'hF;
        if_b.sample = 4'hF;
        if_c.sample = 4'hF;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1);
        checks++;
        if ({if_a.level, if_a.rise, if_a.fall, if_a.rpt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_a got %h exp 0", {if_a.level, if_a.rise, if_a.fall, if_a.rpt});
        end
        checks++;
        if ({if_b.level, if_b.rise, if_b.fall, if_b.rpt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_b got %h exp 0", {if_b.level, if_b.rise, if_b.fall, if_b.rpt});
        end
        checks++;
        if ({if_c.level, if_c.rise, if_c.fall, if_c.rpt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_c got %h exp 0", {if_c.level, if_c.rise, if_c.fall, if_c.rpt});
        end
        do_reset();
    endtask

    // Tick every 4th clk: sync lands at edge 2, ticks at 4..36, rise after edge 36.
    task automatic test_single_rise();
        logic [3:0] exp;
        do_reset();
        if_a.sample[0] = 1'b1;
        for (int i = 1; i <= 44; i++) begin
            step(i % 4 == 0);
            exp = {i >= 36, i == 36, 1'b0, 1'b0};
            checks++;
            if ({if_a.level[0], if_a.rise[0], if_a.fall[0], if_a.rpt[0]} !== exp) begin
                errors++;
                $display("FAIL single_rise cyc %0d got %b exp %b", i,
                         {if_a.level[0], if_a.rise[0], if_a.fall[0], if_a.rpt[0]}, exp);
            end
        end
    endtask

    // Bounce 1,0,1,1,0 then hold 1: last restart at edge 7, rise after edge 16.
    task automatic test_bounce();
        logic [3:0] exp;
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            if_a.sample[1] = !(i == 2 || i == 5);
            step(1'b1);
            exp = {i >= 16, i == 16, 1'b0, 1'b0};
            checks++;
            if ({if_a.level[1], if_a.rise[1], if_a.fall[1], if_a.rpt[1]} !== exp) begin
                errors++;
                $display("FAIL bounce cyc %0d got %b exp %b", i,
                         {if_a.level[1], if_a.rise[1], if_a.fall[1], if_a.rpt[1]}, exp);
            end
        end
    endtask

    // Rise at 11, repeats on ticks 5,7,9.. after it (16,18,..,34), fall at 36 with no repeat.
    task automatic test_repeat();
        logic [3:0] exp;
        do_reset();
        for (int i = 1; i <= 50; i++) begin
            if_b.sample[2] = (i < 26);
            step(1'b1);
            exp = {(i >= 11 && i < 36), i == 11, i == 36, (i >= 16 && i <= 34 && i % 2 == 0)};
            checks++;
            if ({if_b.level[2], if_b.rise[2], if_b.fall[2], if_b.rpt[2]} !== exp) begin
                errors++;
                $display("FAIL repeat cyc %0d got %b exp %b", i,
                         {if_b.level[2], if_b.rise[2], if_b.fall[2], if_b.rpt[2]}, exp);
            end
        end
    endtask

    // Channel 3 reaches cnt=5 when channel 0 rises; async reset must wipe both.
    task automatic test_reset_mid();
        do_reset();
        if_a.sample[0] = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            if (i == 5) if_a.sample[3] = 1'b1;
            step(1'b1);
        end
        checks++;
        if ({if_a.level, if_a.rise} !== 8'b0001_0001) begin
            errors++;
            $display("FAIL reset_mid_pre got %b exp 00010001", {if_a.level, if_a.rise});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({if_a.level, if_a.rise, if_a.fall, if_a.rpt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_async got %h exp 0", {if_a.level, if_a.rise, if_a.fall, if_a.rpt});
        end
        step(1'b1);
        step(1'b1);
        checks++;
        if ({if_a.level, if_a.rise, if_a.fall, if_a.rpt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_hold got %h exp 0", {if_a.level, if_a.rise, if_a.fall, if_a.rpt});
        end
        rst = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step(1'b1);
            checks++;
            if ({if_a.level, if_a.rise, if_a.fall} !==
                {(i >= 11) ? 4'b1001 : 4'b0000, (i == 11) ? 4'b1001 : 4'b0000, 4'b0000}) begin
                errors++;
                $display("FAIL reset_mid_requal cyc %0d got %b", i, {if_a.level, if_a.rise, if_a.fall});
            end
        end
    endtask

    // All channels together; 4 ticks, 20 frozen clks, 5 more ticks -> rise at 31, clears at 32 with tick low.
    task automatic test_simultaneous_freeze();
        logic t;
        do_reset();
        if_a.sample = 4'hF;
        for (int i = 1; i <= 35; i++) begin
            t = (i <= 6) || (i >= 27 && i <= 31) || (i >= 33);
            step(t);
            checks++;
            if ({if_a.level, if_a.rise, if_a.fall, if_a.rpt} !==
                {(i >= 31) ? 4'hF : 4'h0, (i == 31) ? 4'hF : 4'h0, 8'h00}) begin
                errors++;
                $display("FAIL simul_freeze cyc %0d got %h", i, {if_a.level, if_a.rise, if_a.fall, if_a.rpt});
            end
        end
    endtask

    // STABLE_CNT=1: rise on the first tick seeing s (edge 3); repeat never fires.
    task automatic test_fast();
        logic [2:0] exp;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            if_c.sample[0] = (i < 31);
            step(1'b1);
            exp = {(i >= 3 && i < 33), i == 3, i == 33};
            checks++;
            if ({if_c.level[0], if_c.rise[0], if_c.fall[0]} !== exp || if_c.rpt !== 4'h0) begin
                errors++;
                $display("FAIL fast cyc %0d got %b rpt %b exp %b rpt 0000", i,
                         {if_c.level[0], if_c.rise[0], if_c.fall[0]}, if_c.rpt, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if_a.tick = 1'b0; if_b.tick = 1'b0; if_c.tick = 1'b0;
        if_a.sample = '0; if_b.sample = '0; if_c.sample = '0;
        test_reset();
        test_single_rise();
        test_bounce();
        test_repeat();
        test_reset_mid();
        test_simultaneous_freeze();
        test_fast();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
